// File: rtl/ppu_row_scheduler.sv
// ppu_row_scheduler: paces the PPU row renderer against HDMI line timing.
// Each PPU row is prepared one display row ahead: a rowram_swap pulse hands the
// freshly prepared back buffer to the display and asks ppu_logic for next_row.
// The CPU scroll value is double-buffered so one frame renders with one scroll.
//
// Handshake: rowram_swap is a single-cycle strobe with no back-pressure.
// next_row is valid in the cycle rowram_swap is high and is held until the next
// swap. ppu_row_done is sampled in the strobe cycle that decides a non-prime
// swap. A low value in that cycle counts as an overrun.
//
// Line repeat: rep counts HDMI lines already started for the row currently on
// screen. The swap for a new row happens on the line_start that begins that row.
// After the last row has been shown, the next row boundary moves the FSM to
// VBLANK instead of issuing a swap.
module ppu_row_scheduler #(
    parameter int NUM_ROWS    = 240,
    parameter int LINE_REPEAT = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             frame_start,
    input  logic             line_start,
    input  logic             ppu_row_done,
    input  logic             bgscroll_wr,
    input  logic [31:0]      bgscroll_wrdata,
    output logic             rowram_swap,
    output logic [7:0]       next_row,
    output logic [31:0]      bgscroll,
    output logic             busy,
    output logic [CNT_W-1:0] overrun_cnt,
    input  logic             overrun_clr,
    output logic [1:0]       state_dbg
);

    localparam int REP_W = (LINE_REPEAT > 1) ? $clog2(LINE_REPEAT) : 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(LINE_REPEAT - 1);
    localparam logic [9:0]       NR       = 10'(NUM_ROWS);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        ACTIVE = 2'd2,
        VBLANK = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      pending_q, pending_d;
    logic [31:0]      bgscroll_q, bgscroll_d;
    logic [7:0]       disp_q, disp_d;
    logic [7:0]       next_row_q, next_row_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic             swap_q, swap_d;
    logic             busy_q;
    logic             prime;
    logic [CNT_W-1:0] cnt_q;
    logic [9:0]       d_nxt;
    logic [9:0]       d_pre;

    assign d_nxt = {2'b00, disp_q} + 10'd1;
    assign d_pre = d_nxt + 10'd1;

    // Next-state and registered-output decode; enable low dominates, frame_start beats line_start.
    always_comb begin
        state_d    = state_q;
        swap_d     = 1'b0;
        next_row_d = next_row_q;
        disp_d     = disp_q;
        rep_d      = rep_q;
        bgscroll_d = bgscroll_q;
        prime      = 1'b0;
        pending_d  = bgscroll_wr ? bgscroll_wrdata : pending_q;
        if (!enable) begin
            state_d = IDLE;
        end else if (frame_start) begin
            prime      = 1'b1;
            swap_d     = 1'b1;
            next_row_d = 8'd0;
            disp_d     = 8'd0;
            rep_d      = '0;
            bgscroll_d = bgscroll_wr ? bgscroll_wrdata : pending_q;
            state_d    = PRIME;
        end else if (line_start) begin
            case (state_q)
                PRIME: begin
                    swap_d     = 1'b1;
                    next_row_d = (NUM_ROWS == 1) ? 8'd0 : 8'd1;
                    disp_d     = 8'd0;
                    rep_d      = '0;
                    state_d    = ACTIVE;
                end
                ACTIVE: begin
                    if (rep_q != REP_LAST) begin
                        rep_d = rep_q + REP_W'(1);
                    end else begin
                        rep_d = '0;
                        if (d_nxt < NR) begin
                            disp_d     = d_nxt[7:0];
                            swap_d     = 1'b1;
                            next_row_d = (d_pre < NR) ? d_pre[7:0] : 8'd0;
                        end else begin
                            state_d = VBLANK;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            bgscroll_q <= '0;
            disp_q     <= '0;
            next_row_q <= '0;
            rep_q      <= '0;
            swap_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            bgscroll_q <= bgscroll_d;
            disp_q     <= disp_d;
            next_row_q <= next_row_d;
            rep_q      <= rep_d;
            swap_q     <= swap_d;
            busy_q     <= (state_d == PRIME) || (state_d == ACTIVE);
        end
    end

    // Saturating overrun counter; clear wins over a same-cycle late row.
    always_ff @(posedge clk) begin
        if (rst || overrun_clr) begin
            cnt_q <= '0;
        end else if (swap_d && !prime && !ppu_row_done && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign rowram_swap = swap_q;
    assign next_row    = next_row_q;
    assign bgscroll    = bgscroll_q;
    assign busy        = busy_q;
    assign overrun_cnt = cnt_q;
    assign state_dbg   = state_q;

endmodule
